// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and width helper for the debounce scan scheduler
package debounce_pkg;

    typedef enum logic {
        s_IDLE    = 1'b0,
        s_PRESENT = 1'b1
    } evt_state_t;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_scan_scheduler_rr_arbiter.sv
// rtl/debounce_scan_scheduler_rr_arbiter.sv - combinational round-robin picker over pending channels
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_any
);

    int idx;

    // Walk from the farthest candidate back to ptr so the closest request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_scan_scheduler.sv
// rtl/debounce_scan_scheduler.sv - shared time-multiplexed debouncer with round-robin event port
module debounce_scan_scheduler
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 3,
    localparam int CH_W      = ch_w(N_CH)
) (
    input  logic            i_CLK,
    input  logic            i_RST_N,
    input  logic            i_Enable,
    input  logic [N_CH-1:0] i_Signal,
    output logic [N_CH-1:0] o_Level,
    output logic            o_Event_Valid,
    input  logic            i_Event_Ready,
    output logic [CH_W-1:0] o_Event_Ch,
    output logic            o_Event_Press,
    output logic            o_Overrun
);

    localparam int DIV_W = $clog2(TICK_DIV);

    logic [N_CH-1:0]  sync1, sync2;
    logic [DIV_W-1:0] presc;
    logic [CH_W-1:0]  scan;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  pend, pol, pend_nxt;
    logic [CH_W-1:0]  rr_ptr;
    evt_state_t       state;

    logic             tick, sample, new_evt, grant_fire;
    logic [N_CH-1:0]  grant_oh, set_oh;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_any;

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req       (pend),
        .ptr       (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        tick       = i_Enable && (presc == DIV_W'(TICK_DIV - 1));
        sample     = sync2[scan];
        new_evt    = tick && (sample != o_Level[scan]) && (cnt[scan] == CNT_W'(STABLE_CNT - 1));
        grant_fire = (state == s_IDLE) && grant_any;
        set_oh     = '0;
        if (new_evt) set_oh[scan] = 1'b1;
        // A fresh event on the channel being granted stays pending.
        pend_nxt   = (pend & ~(grant_fire ? grant_oh : '0)) | set_oh;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sync1     <= '0;
            sync2     <= '0;
            presc     <= '0;
            scan      <= '0;
            o_Level   <= '0;
            pend      <= '0;
            pol       <= '0;
            o_Overrun <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= i_Signal;
            sync2 <= sync1;
            pend  <= pend_nxt;
            if (!i_Enable || tick) presc <= '0;
            else                   presc <= presc + 1'b1;
            if (tick) begin
                scan <= (scan == CH_W'(N_CH - 1)) ? '0 : scan + 1'b1;
                if (sample == o_Level[scan]) begin
                    cnt[scan] <= '0;
                end else if (new_evt) begin
                    o_Level[scan] <= sample;
                    pol[scan]     <= sample;
                    cnt[scan]     <= '0;
                    // Only an event that is neither granted nor reported is lost.
                    if (pend[scan] && !(grant_fire && grant_oh[scan])) o_Overrun <= 1'b1;
                end else begin
                    cnt[scan] <= cnt[scan] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state         <= s_IDLE;
            o_Event_Valid <= 1'b0;
            o_Event_Ch    <= '0;
            o_Event_Press <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            case (state)
                s_IDLE: begin
                    if (grant_any) begin
                        o_Event_Ch    <= grant_idx;
                        o_Event_Press <= pol[grant_idx];
                        rr_ptr        <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                        o_Event_Valid <= 1'b1;
                        state         <= s_PRESENT;
                    end
                end
                s_PRESENT: begin
                    if (i_Event_Ready) begin
                        o_Event_Valid <= 1'b0;
                        state         <= s_IDLE;
                    end
                end
                default: state <= s_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb/tb_debounce_scan_scheduler.sv - directed table plus randomized model check of the debouncer
module tb_debounce_scan_scheduler;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;

    logic       clk, rst_n, en, rdy;
    logic [3:0] sig;
    logic [3:0] level;
    logic       valid, press, ovr;
    logic [1:0] ch;

    int checks = 0;
    int errors = 0;
    int hs;
    int last_ch;
    logic last_press;

    debounce_scan_scheduler #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC), .CNT_W(3)) dut (
        .i_CLK         (clk),
        .i_RST_N       (rst_n),
        .i_Enable      (en),
        .i_Signal      (sig),
        .o_Level       (level),
        .o_Event_Valid (valid),
        .i_Event_Ready (rdy),
        .o_Event_Ch    (ch),
        .o_Event_Press (press),
        .o_Overrun     (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: synchronizer delay line, enabled-cycle divider, per-channel run of
    // disagreeing samples, pending event slots and a one-deep presented event.
    bit [3:0] m_s1, m_s2, m_level, m_pend, m_pol;
    int       m_run [N];
    int       m_div, m_scan, m_rr, m_ch;
    bit       m_valid, m_press, m_ovr;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_pend = 0; m_pol = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_div = 0; m_scan = 0; m_rr = 0; m_ch = 0;
        m_valid = 0; m_press = 0; m_ovr = 0;
    endtask

    task automatic model_step(input logic [3:0] s, input logic e, input logic r, input logic rs);
        int gnt, p;
        bit tick, nev;
        if (!rs) begin
            model_reset();
            return;
        end
        tick  = e && (m_div == TD - 1);
        m_div = (!e || tick) ? 0 : m_div + 1;
        gnt = -1;
        if (!m_valid)
            for (int k = N - 1; k >= 0; k--)
                if (m_pend[(m_rr + k) % N]) gnt = (m_rr + k) % N;
        nev = 0;
        p   = m_scan;
        if (tick) begin
            if (m_s2[p] == m_level[p]) m_run[p] = 0;
            else if (m_run[p] + 1 == SC) begin
                m_level[p] = ~m_level[p];
                m_run[p]   = 0;
                nev        = 1;
            end else m_run[p] = m_run[p] + 1;
            m_scan = (p + 1) % N;
        end
        if (m_valid) begin
            if (r) m_valid = 0;
        end else if (gnt >= 0) begin
            m_valid    = 1;
            m_ch       = gnt;
            m_press    = m_pol[gnt];
            m_pend[gnt] = 0;
            m_rr       = (gnt + 1) % N;
        end
        if (nev) begin
            if (m_pend[p]) m_ovr = 1;
            m_pend[p] = 1;
            m_pol[p]  = m_level[p];
        end
        m_s2 = m_s1;
        m_s1 = s;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [8:0] got, exp;
        got = {level, valid, ch, press, ovr};
        exp = {m_level, m_valid, 2'(m_ch), m_press, m_ovr};
        chk("model {level,valid,ch,press,ovr}", int'(got), int'(exp));
    endtask

    task automatic cycle(input logic [3:0] s, input logic e, input logic r);
        sig = s; en = e; rdy = r;
        if (rst_n && valid && r) begin
            hs++;
            last_ch    = int'(ch);
            last_press = press;
        end
        model_step(s, e, r, rst_n);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [3:0] sig;
        logic       en;
        logic       rdy;
        int         cycles;
        logic [3:0] lvl;
        int         ev;
        logic       ovr;
    } row_t;

    row_t rows [10];

    task automatic run_row(input int i);
        hs = 0;
        repeat (rows[i].cycles) cycle(rows[i].sig, rows[i].en, rows[i].rdy);
        chk($sformatf("row%0d level", i), int'(level), int'(rows[i].lvl));
        chk($sformatf("row%0d events", i), hs, rows[i].ev);
        chk($sformatf("row%0d overrun", i), int'(ovr), int'(rows[i].ovr));
    endtask

    initial begin
        int first;
        logic [3:0] rs;

        rows[0] = '{4'b0000, 1'b1, 1'b1, 200, 4'b0000, 0, 1'b0};
        rows[1] = '{4'b0010, 1'b1, 1'b1,  64, 4'b0010, 1, 1'b0};
        rows[2] = '{4'b0110, 1'b1, 1'b1,  24, 4'b0010, 0, 1'b0};
        rows[3] = '{4'b0010, 1'b1, 1'b1,  40, 4'b0010, 0, 1'b0};
        rows[4] = '{4'b0000, 1'b1, 1'b1,  64, 4'b0000, 1, 1'b0};
        rows[5] = '{4'b1001, 1'b1, 1'b0,  64, 4'b1001, 0, 1'b0};
        rows[6] = '{4'b1011, 1'b1, 1'b0,  64, 4'b1011, 0, 1'b0};
        rows[7] = '{4'b1001, 1'b1, 1'b0,  64, 4'b1001, 0, 1'b1};
        rows[8] = '{4'b0110, 1'b0, 1'b1, 100, 4'b1001, 2, 1'b1};
        rows[9] = '{4'b0110, 1'b1, 1'b0,  64, 4'b0110, 0, 1'b1};

        clk = 0; rst_n = 0; en = 1;
        sig = 4'($urandom); rdy = 1'($urandom);
        last_ch = 0; last_press = 0; hs = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({level, valid, ch, press, ovr}), 0);
        rst_n = 1;

        for (int i = 0; i <= 5; i++) run_row(i);

        // Two channels pending: hold, accept one for a single cycle, expect a bubble then the other.
        first = m_ch;
        chk("held valid", int'(valid), 1);
        chk("first grant is ch0 or ch3", int'(first == 0 || first == 3), 1);
        cycle(4'b1001, 1'b1, 1'b1);
        chk("bubble after accept", int'(valid), 0);
        cycle(4'b1001, 1'b1, 1'b0);
        chk("second valid", int'(valid), 1);
        chk("second ch", int'(ch), 3 - first);
        chk("second press", int'(press), 1);

        for (int i = 6; i <= 8; i++) run_row(i);
        chk("overwritten event ch", last_ch, 1);
        chk("overwritten event press", int'(last_press), 0);

        run_row(9);
        chk("valid before reset", int'(valid), 1);
        #1 rst_n = 0;
        model_reset();
        #1;
        chk("async reset clears", int'({level, valid, ch, press, ovr}), 0);
        @(negedge clk);
        cycle(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1;

        rs = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 29) == 0) rs[b] = ~rs[b];
            cycle(rs, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
